ser8_loader: RTL and testbench

Serial-to-parallel front end for the 8-bit enable register. It assembles one byte from a bit-serial stream, checks a trailing parity bit, and presents the byte on a parallel bus together with a one-cycle load enable. The outputs `Data_Out`/`EN_Out` connect directly to the register's `Reg_In`/`EN` inputs, and both blocks share `clk`/`res`.

---
 rtl/ser8_loader_pkg.sv | 24 ++
 rtl/ser8_loader_shift8.sv | 33 +++
 rtl/ser8_loader.sv | 137 +++++++++++++
 tb/tb_ser8_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ser8_loader_pkg.sv
// Shared definitions for the ser8_loader serial-to-parallel front end:
// FSM encodings, datapath widths and the parity helper.
package ser8_loader_pkg;

  localparam int SER8_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0] CNT_ZERO = 3'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // acc is the running XOR of the data bits; the frame is good when folding
  // in the parity bit yields the selected parity sense.
  function automatic logic parity_ok(input logic acc, input logic par_bit, input logic odd);
    return ((acc ^ par_bit) == odd);
  endfunction

endpackage

// File: rtl/ser8_loader_shift8.sv
// 8-bit serial-in/parallel-out shift register; msb_first selects whether the
// first bit shifted in ends up at bit 7 (left shift) or bit 0 (right shift).
module shift8
  import ser8_loader_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              shift_en,
  input  logic              ser_in,
  input  logic              msb_first,
  output logic [SER8_W-1:0] par_out
);

  logic [SER8_W-1:0] shreg_r;

  // Shift one bit per enabled edge; hold otherwise.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      shreg_r <= 8'h00;
    end else if (shift_en) begin
      if (msb_first) begin
        shreg_r <= {shreg_r[SER8_W-2:0], ser_in};
      end else begin
        shreg_r <= {ser_in, shreg_r[SER8_W-1:1]};
      end
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign par_out = shreg_r;

endmodule

// File: rtl/ser8_loader.sv
// Serial-to-parallel loader for the 8-bit enable register: assembles a byte,
// checks the trailing parity bit and issues a one-cycle load strobe.
module ser8_loader
  import ser8_loader_pkg::*;
#(
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              Frm_Start,
  input  logic              Ser_Vld,
  input  logic              Ser_In,
  output logic [SER8_W-1:0] Data_Out,
  output logic              EN_Out,
  output logic              Par_Err,
  output logic              Busy
);

  localparam logic ODD_L = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam logic MSB_L = (MSB_FIRST != 0) ? 1'b1 : 1'b0;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              par_acc_r;
  logic              par_acc_nxt_s;
  logic              shift_en_s;
  logic              load_s;
  logic              err_s;
  logic [SER8_W-1:0] shreg_s;
  logic [SER8_W-1:0] data_r;
  logic              en_r;
  logic              perr_r;
  logic              busy_r;

  shift8 u_shift8 (
    .clk       (clk),
    .res       (res),
    .shift_en  (shift_en_s),
    .ser_in    (Ser_In),
    .msb_first (MSB_L),
    .par_out   (shreg_s)
  );

  // Next-state, counter, parity accumulator and strobe decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    par_acc_nxt_s = par_acc_r;
    shift_en_s    = 1'b0;
    load_s        = 1'b0;
    err_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Ser_Vld on the start cycle is deliberately ignored.
        if (Frm_Start) begin
          state_nxt_s   = ST_SHIFT;
          cnt_nxt_s     = CNT_ZERO;
          par_acc_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (Ser_Vld) begin
          shift_en_s    = 1'b1;
          cnt_nxt_s     = cnt_r + CNT_ONE;
          par_acc_nxt_s = par_acc_r ^ Ser_In;
          if (cnt_r == CNT_MAX) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_PARITY: begin
        if (Ser_Vld) begin
          state_nxt_s = ST_IDLE;
          if (parity_ok(par_acc_r, Ser_In, ODD_L)) begin
            load_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = CNT_ZERO;
        par_acc_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, bit counter and parity accumulator registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      par_acc_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      par_acc_r <= par_acc_nxt_s;
    end
  end

  // Output registers: byte is only replaced on a good frame; strobes last one cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      data_r <= 8'h00;
      en_r   <= 1'b0;
      perr_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      if (load_s) begin
        data_r <= shreg_s;
      end else begin
        data_r <= data_r;
      end
      en_r   <= load_s;
      perr_r <= err_s;
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign Data_Out = data_r;
  assign EN_Out   = en_r;
  assign Par_Err  = perr_r;
  assign Busy     = busy_r;

endmodule

// File: tb/tb_ser8_loader.sv
// Directed bench for ser8_loader: three instances (default, LSB-first, odd
// parity) share one stimulus stream; a downstream register models the consumer.
module tb_ser8_loader;

  logic       clk;
  logic       res;
  logic       Frm_Start;
  logic       Ser_Vld;
  logic       Ser_In;
  logic [7:0] d0, d1, d2;
  logic       en0, en1, en2;
  logic       pe0, pe1, pe2;
  logic       bz0, bz1, bz2;
  logic [7:0] reg_q;
  int         cyc;
  int         checks;
  int         failures;
  int         busy_drop;
  int         t1, t2;

  ser8_loader #(.PARITY_ODD(0), .MSB_FIRST(1)) dut0 (
    .clk(clk), .res(res), .Frm_Start(Frm_Start), .Ser_Vld(Ser_Vld), .Ser_In(Ser_In),
    .Data_Out(d0), .EN_Out(en0), .Par_Err(pe0), .Busy(bz0));

  ser8_loader #(.PARITY_ODD(0), .MSB_FIRST(0)) dut1 (
    .clk(clk), .res(res), .Frm_Start(Frm_Start), .Ser_Vld(Ser_Vld), .Ser_In(Ser_In),
    .Data_Out(d1), .EN_Out(en1), .Par_Err(pe1), .Busy(bz1));

  ser8_loader #(.PARITY_ODD(1), .MSB_FIRST(1)) dut2 (
    .clk(clk), .res(res), .Frm_Start(Frm_Start), .Ser_Vld(Ser_Vld), .Ser_In(Ser_In),
    .Data_Out(d2), .EN_Out(en2), .Par_Err(pe2), .Busy(bz2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or posedge res) begin
    if (res) reg_q <= 8'h00;
    else if (en0) reg_q <= d0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start cycle drives Ser_Vld=1 as well; that bit must not be taken.
  task automatic send_frame(input logic [7:0] b, input logic p, input int gap, input bit mid_start);
    Frm_Start = 1'b1; Ser_Vld = 1'b1; Ser_In = 1'b1;
    @(negedge clk);
    Frm_Start = 1'b0; Ser_Vld = 1'b0;
    busy_drop = 0;
    for (int i = 7; i >= 0; i--) begin
      Ser_Vld = 1'b1; Ser_In = b[i];
      Frm_Start = (mid_start && (i == 4)) ? 1'b1 : 1'b0;
      @(negedge clk);
      Ser_Vld = 1'b0; Frm_Start = 1'b0;
      if (bz0 !== 1'b1) busy_drop++;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (bz0 !== 1'b1) busy_drop++;
      end
    end
    Ser_Vld = 1'b1; Ser_In = p;
    @(negedge clk);
    Ser_Vld = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; busy_drop = 0; cyc = 0;
    res = 1'b0; Frm_Start = 1'b0; Ser_Vld = 1'b0; Ser_In = 1'b0;

    #4 res = 1'b1;
    #1;
    chk("rst_data", {24'd0, d0}, 32'h00);
    chk("rst_en",   {31'd0, en0}, 32'd0);
    chk("rst_perr", {31'd0, pe0}, 32'd0);
    chk("rst_busy", {31'd0, bz0}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // 8'h77 has six ones: even parity bit 0.
    send_frame(8'h77, 1'b0, 0, 1'b0);
    chk("f77_en",   {31'd0, en0}, 32'd1);
    chk("f77_data", {24'd0, d0}, 32'h77);
    chk("f77_perr", {31'd0, pe0}, 32'd0);
    chk("f77_busy", {31'd0, bz0}, 32'd0);
    chk("f77_odd_perr", {31'd0, pe2}, 32'd1);
    @(negedge clk);
    chk("f77_en_clr", {31'd0, en0}, 32'd0);
    chk("f77_reg",    {24'd0, reg_q}, 32'h77);

    send_frame(8'h77, 1'b1, 0, 1'b0);
    chk("perr_pe",   {31'd0, pe0}, 32'd1);
    chk("perr_en",   {31'd0, en0}, 32'd0);
    chk("perr_data", {24'd0, d0}, 32'h77);
    @(negedge clk);
    chk("perr_pe_clr", {31'd0, pe0}, 32'd0);
    chk("perr_reg",    {24'd0, reg_q}, 32'h77);

    // 8'hA5 has four ones: parity 0; three idle cycles after every bit.
    send_frame(8'hA5, 1'b0, 3, 1'b0);
    chk("gap_en",   {31'd0, en0}, 32'd1);
    chk("gap_data", {24'd0, d0}, 32'hA5);
    chk("gap_busy_held", busy_drop, 32'd0);
    @(negedge clk);

    // Second start sampled at k+1, so pulses are one 10-edge frame apart.
    send_frame(8'h01, 1'b1, 0, 1'b0);
    t1 = cyc;
    chk("b2b1_en",   {31'd0, en0}, 32'd1);
    chk("b2b1_data", {24'd0, d0}, 32'h01);
    send_frame(8'hFE, 1'b1, 0, 1'b1);
    t2 = cyc;
    chk("b2b2_en",   {31'd0, en0}, 32'd1);
    chk("b2b2_data", {24'd0, d0}, 32'hFE);
    chk("b2b_spacing", t2 - t1, 32'd10);
    @(negedge clk);

    // Abort after five data bits.
    Frm_Start = 1'b1;
    @(negedge clk);
    Frm_Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Ser_Vld = 1'b1; Ser_In = 1'b1;
      @(negedge clk);
    end
    Ser_Vld = 1'b0;
    chk("abort_busy_pre", {31'd0, bz0}, 32'd1);
    #2 res = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bz0}, 32'd0);
    chk("abort_data", {24'd0, d0}, 32'h00);
    chk("abort_en",   {31'd0, en0}, 32'd0);
    chk("abort_perr", {31'd0, pe0}, 32'd0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("abort_en_post",   {31'd0, en0}, 32'd0);
    chk("abort_perr_post", {31'd0, pe0}, 32'd0);

    // Stream 1,0,0,0,0,0,0,0 then parity 1.
    send_frame(8'h80, 1'b1, 0, 1'b0);
    chk("lsb_en",   {31'd0, en1}, 32'd1);
    chk("lsb_data", {24'd0, d1}, 32'h01);
    chk("msb_data", {24'd0, d0}, 32'h80);
    @(negedge clk);

    // Zero byte with parity 1: good only in odd mode.
    send_frame(8'h00, 1'b1, 0, 1'b0);
    chk("odd_en",    {31'd0, en2}, 32'd1);
    chk("odd_data",  {24'd0, d2}, 32'h00);
    chk("odd_perr",  {31'd0, pe2}, 32'd0);
    chk("even_perr", {31'd0, pe0}, 32'd1);
    chk("even_en",   {31'd0, en0}, 32'd0);
    @(negedge clk);
    chk("odd_en_clr", {31'd0, en2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
